jk_cmd_sequencer: RTL and testbench

Command-driven stimulus stage that sits directly upstream of the JK flip-flop. It buffers 2-bit commands (HOLD, RESET, SET, TOGGLE) in a small FIFO and issues each one as a single-cycle J/K pair. It keeps a reference model of the flip-flop's expected output and checks the flip-flop's returned q one cycle after every issue, flagging mismatches.

---
 rtl/jk_cmd_sequencer.sv | 178 +++++++++++++++++
 tb/tb_jk_cmd_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_sequencer.sv
// Command FIFO that drives a JK flip-flop one single-cycle J/K pulse per command,
// tracks the expected q and flags any returned q that disagrees.
module jk_cmd_sequencer #(
  parameter int DEPTH    = 4,
  parameter int PERIOD_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd,
  input  logic [PERIOD_W-1:0]       gap,
  output logic                      j,
  output logic                      k,
  output logic                      issue,
  input  logic                      q_in,
  output logic                      q_exp,
  output logic                      mismatch,
  output logic [7:0]                err_count,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 + PERIOD_W;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CHECK, S_GAP} state_t;

  state_t               state_q, state_d;
  logic [ENT_W-1:0]     mem_q [DEPTH];
  logic [ENT_W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PERIOD_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic                 j_q, j_d, k_q, k_d;
  logic                 q_exp_q, q_exp_d;
  logic                 mismatch_q, mismatch_d;
  logic [7:0]           err_count_q, err_count_d;

  logic                 push, pop, full, has_cmd;
  logic [ENT_W-1:0]     head;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign has_cmd = (count_q != '0);
  assign push    = cmd_valid && !full;
  assign head    = mem_q[rd_ptr_q];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state; a pop happens only on entry to ISSUE
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (has_cmd) begin
          state_d = S_ISSUE;
          pop     = 1'b1;
        end
      end
      S_ISSUE: state_d = S_CHECK;
      S_CHECK: begin
        if (gap_cnt_q != '0) begin
          state_d = S_GAP;
        end else if (has_cmd) begin
          state_d = S_ISSUE;
          pop     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= PERIOD_W'(1)) begin
          if (has_cmd) begin
            state_d = S_ISSUE;
            pop     = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    issue = (state_q == S_ISSUE);
    busy  = (state_q != S_IDLE) || has_cmd;
  end

  // Datapath: FIFO, J/K drive, reference model, error tracking
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    gap_cnt_d   = gap_cnt_q;
    j_d         = 1'b0;
    k_d         = 1'b0;
    q_exp_d     = q_exp_q;
    mismatch_d  = mismatch_q;
    err_count_d = err_count_q;

    if (push) begin
      mem_d[wr_ptr_q] = {cmd, gap};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      j_d       = head[ENT_W-1];
      k_d       = head[ENT_W-2];
      gap_cnt_d = head[PERIOD_W-1:0];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (state_q == S_ISSUE) begin
      case ({j_q, k_q})
        2'b01:   q_exp_d = 1'b0;
        2'b10:   q_exp_d = 1'b1;
        2'b11:   q_exp_d = ~q_exp_q;
        default: q_exp_d = q_exp_q;
      endcase
    end

    if (state_q == S_CHECK && q_in != q_exp_q) begin
      mismatch_d = 1'b1;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end

    if (state_q == S_GAP && gap_cnt_q > PERIOD_W'(1)) gap_cnt_d = gap_cnt_q - PERIOD_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      gap_cnt_q   <= '0;
      j_q         <= 1'b0;
      k_q         <= 1'b0;
      q_exp_q     <= 1'b0;
      mismatch_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      gap_cnt_q   <= gap_cnt_d;
      j_q         <= j_d;
      k_q         <= k_d;
      q_exp_q     <= q_exp_d;
      mismatch_q  <= mismatch_d;
      err_count_q <= err_count_d;
    end
  end

  assign cmd_ready = !full;
  assign j         = j_q;
  assign k         = k_q;
  assign q_exp     = q_exp_q;
  assign mismatch  = mismatch_q;
  assign err_count = err_count_q;
  assign count     = count_q;

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench: a behavioural JK flip-flop closes the loop; each task checks one scenario.
module tb_jk_cmd_sequencer;

  localparam logic [1:0] C_HOLD = 2'b00, C_RST = 2'b01, C_SET = 2'b10, C_TOG = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd = 2'b00;
  logic [3:0] gap = 4'd0;
  logic       j, k, issue, q_in, q_exp, mismatch, busy;
  logic [7:0] err_count;
  logic [2:0] count;

  logic       q_ff = 1'b0;
  logic       force_zero = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int max_count = 0;
  int jk_hi = 0;
  logic prev_issue = 1'b0;
  int         log_cyc[$];
  logic [1:0] log_jk[$];
  logic       log_q[$];

  jk_cmd_sequencer #(.DEPTH(4), .PERIOD_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .gap(gap), .j(j), .k(k), .issue(issue), .q_in(q_in),
    .q_exp(q_exp), .mismatch(mismatch), .err_count(err_count),
    .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Flip-flop under test: no reset, samples j/k on the rising edge
  always @(posedge clk) begin
    cyc <= cyc + 1;
    case ({j, k})
      2'b01:   q_ff <= 1'b0;
      2'b10:   q_ff <= 1'b1;
      2'b11:   q_ff <= ~q_ff;
      default: q_ff <= q_ff;
    endcase
  end

  assign q_in = force_zero ? 1'b0 : q_ff;

  // Log each issue pulse and the expected q visible in the following (CHECK) cycle
  always @(negedge clk) begin
    if (issue) begin
      log_cyc.push_back(cyc);
      log_jk.push_back({j, k});
    end
    if (prev_issue) log_q.push_back(q_exp);
    prev_issue <= issue;
    if (int'(count) > max_count) max_count <= int'(count);
    if (j || k) jk_hi <= jk_hi + 1;
  end

  task clear_log();
    log_cyc.delete();
    log_jk.delete();
    log_q.delete();
  endtask

  task push_cmd(input logic [1:0] c, input logic [3:0] g);
    int n;
    n = 0;
    cmd = c; gap = g; cmd_valid = 1'b1;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%b required 0", busy);
    end
    @(negedge clk);
  endtask

  task test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", cmd_ready); end
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL rst_count: got %0d want 0", count); end
    checks++; if ({j, k} !== 2'b00)   begin errors++; $display("FAIL rst_jk: got %b want 00", {j, k}); end
    checks++; if (issue !== 1'b0)     begin errors++; $display("FAIL rst_issue: got %b want 0", issue); end
    checks++; if (q_exp !== 1'b0)     begin errors++; $display("FAIL rst_qexp: got %b want 0", q_exp); end
    checks++; if (mismatch !== 1'b0)  begin errors++; $display("FAIL rst_mismatch: got %b want 0", mismatch); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rst_err: got %0d want 0", err_count); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task test_sequence();
    logic [1:0] exp_jk [5];
    logic       exp_q  [5];
    exp_jk = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b00};
    exp_q  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    clear_log();
    for (int i = 0; i < 5; i++) push_cmd(exp_jk[i], 4'd0);
    wait_idle();
    checks++;
    if (log_q.size() != 5) begin
      errors++; $display("FAIL seq_len: got %0d issues want 5", log_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (log_jk[i] !== exp_jk[i]) begin errors++; $display("FAIL seq_jk[%0d]: got %b want %b", i, log_jk[i], exp_jk[i]); end
        checks++; if (log_q[i] !== exp_q[i])   begin errors++; $display("FAIL seq_qexp[%0d]: got %b want %b", i, log_q[i], exp_q[i]); end
      end
      for (int i = 1; i < 5; i++) begin
        checks++; if (log_cyc[i] - log_cyc[i-1] != 2) begin errors++; $display("FAIL seq_spacing[%0d]: got %0d want 2", i, log_cyc[i] - log_cyc[i-1]); end
      end
    end
    checks++; if (mismatch !== 1'b0) begin errors++; $display("FAIL seq_mismatch: got %b want 0", mismatch); end
  endtask

  task test_full();
    max_count = 0;
    push_cmd(C_SET, 4'd15);
    cmd = C_HOLD; gap = 4'd0; cmd_valid = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (count !== 3'd4)     begin errors++; $display("FAIL full_count: got %0d want 4", count); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (count !== 3'd4)     begin errors++; $display("FAIL full_refuse: got %0d want 4", count); end
    wait_idle();
    checks++; if (max_count != 4)     begin errors++; $display("FAIL full_max: got %0d want 4", max_count); end
    checks++; if (q_exp !== 1'b1)     begin errors++; $display("FAIL full_qexp: got %b want 1", q_exp); end
    checks++; if (mismatch !== 1'b0)  begin errors++; $display("FAIL full_mismatch: got %b want 0", mismatch); end
  endtask

  task test_gap();
    clear_log();
    jk_hi = 0;
    push_cmd(C_SET, 4'd3);
    push_cmd(C_TOG, 4'd0);
    wait_idle();
    checks++;
    if (log_q.size() != 2) begin
      errors++; $display("FAIL gap_len: got %0d issues want 2", log_q.size());
    end else begin
      // ISSUE + CHECK + 3 idle cycles between the two issue pulses
      checks++; if (log_cyc[1] - log_cyc[0] != 5) begin errors++; $display("FAIL gap_spacing: got %0d want 5", log_cyc[1] - log_cyc[0]); end
      checks++; if (log_q[0] !== 1'b1) begin errors++; $display("FAIL gap_q0: got %b want 1", log_q[0]); end
      checks++; if (log_q[1] !== 1'b0) begin errors++; $display("FAIL gap_q1: got %b want 0", log_q[1]); end
    end
    checks++; if (jk_hi != 2) begin errors++; $display("FAIL gap_jk_cycles: got %0d want 2", jk_hi); end
  endtask

  task test_mismatch();
    force_zero = 1'b1;
    push_cmd(C_SET, 4'd0);
    wait_idle();
    force_zero = 1'b0;
    checks++; if (mismatch !== 1'b1)  begin errors++; $display("FAIL mm_flag: got %b want 1", mismatch); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL mm_count: got %0d want 1", err_count); end
    push_cmd(C_TOG, 4'd0);
    wait_idle();
    checks++; if (q_exp !== 1'b0)     begin errors++; $display("FAIL mm_qexp: got %b want 0", q_exp); end
    checks++; if (mismatch !== 1'b1)  begin errors++; $display("FAIL mm_sticky: got %b want 1", mismatch); end
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL mm_count2: got %0d want 1", err_count); end
  endtask

  task test_saturate();
    force_zero = 1'b1;
    for (int i = 0; i < 100; i++) push_cmd(C_SET, 4'd0);
    wait_idle();
    checks++; if (err_count !== 8'd101) begin errors++; $display("FAIL sat_mid: got %0d want 101", err_count); end
    for (int i = 0; i < 200; i++) push_cmd(C_SET, 4'd0);
    wait_idle();
    force_zero = 1'b0;
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_cap: got %0d want 255", err_count); end
    checks++; if (mismatch !== 1'b1)    begin errors++; $display("FAIL sat_flag: got %b want 1", mismatch); end
  endtask

  task test_reset_gap();
    push_cmd(C_SET, 4'd15);
    push_cmd(C_HOLD, 4'd0);
    push_cmd(C_HOLD, 4'd0);
    repeat (3) @(negedge clk);
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL rg_queued: got %0d want 2", count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (count !== 3'd0)     begin errors++; $display("FAIL rg_count: got %0d want 0", count); end
    checks++; if ({j, k} !== 2'b00)   begin errors++; $display("FAIL rg_jk: got %b want 00", {j, k}); end
    checks++; if (q_exp !== 1'b0)     begin errors++; $display("FAIL rg_qexp: got %b want 0", q_exp); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rg_busy: got %b want 0", busy); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rg_err: got %0d want 0", err_count); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    repeat (20) @(negedge clk);
    checks++; if (log_cyc.size() != 0) begin errors++; $display("FAIL rg_quiet: got %0d issues want 0", log_cyc.size()); end
    push_cmd(C_RST, 4'd0);
    wait_idle();
    checks++; if (log_cyc.size() != 1) begin errors++; $display("FAIL rg_resume: got %0d issues want 1", log_cyc.size()); end
    checks++; if (q_exp !== 1'b0)      begin errors++; $display("FAIL rg_qexp2: got %b want 0", q_exp); end
    checks++; if (mismatch !== 1'b0)   begin errors++; $display("FAIL rg_mismatch: got %b want 0", mismatch); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_full();
    test_gap();
    test_mismatch();
    test_saturate();
    test_reset_gap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
